alarm_ctrl: RTL and testbench

//  Alarm unit that consumes the hr/min/sec time bus produced by the digital clock block.

---
 rtl/alarm_ctrl_if.sv | 32 +++
 rtl/alarm_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_if.sv
// Time bus from the digital clock plus alarm buttons and alarm status outputs.
interface alarm_ctrl_if;
  // Live time from the clock block
  logic [4:0] hr;
  logic [5:0] min;
  logic [5:0] sec;
  // User buttons (level)
  logic       al_hr_inc;
  logic       al_min_inc;
  logic       arm_tgl;
  logic       snooze;
  logic       stop;
  // Alarm status
  logic [4:0] al_hr;
  logic [5:0] al_min;
  logic       armed;
  logic       ringing;
  logic       snoozing;
  logic       buzzer;

  // Driver side: clock block and button panel
  modport master (
    output hr, min, sec, al_hr_inc, al_min_inc, arm_tgl, snooze, stop,
    input  al_hr, al_min, armed, ringing, snoozing, buzzer
  );

  // Alarm unit side
  modport slave (
    input  hr, min, sec, al_hr_inc, al_min_inc, arm_tgl, snooze, stop,
    output al_hr, al_min, armed, ringing, snoozing, buzzer
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm unit: holds the alarm setting, compares it against live time and
// runs the IDLE/ARMED/RINGING/SNOOZE state machine with snooze and timeout.
// One clk cycle equals one clock second.
module alarm_ctrl #(
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_TIMEOUT = 60,
  parameter int MAX_SNOOZE   = 3,
  parameter int BUZZ_HALF    = 1
) (
  input  logic         clk,
  input  logic         rst,
  alarm_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

  localparam int TW = $clog2(RING_TIMEOUT + 1);
  localparam int BW = $clog2(BUZZ_HALF + 1);
  localparam int CW = $clog2(MAX_SNOOZE + 2);
  localparam logic [TW-1:0] RT_LAST = TW'(RING_TIMEOUT - 1);
  localparam logic [BW-1:0] BH_LAST = BW'(BUZZ_HALF - 1);
  localparam logic [CW-1:0] SN_MAX  = CW'(MAX_SNOOZE);
  localparam logic [6:0]    SN_ADD  = 7'(SNOOZE_MIN);

  state_t          state_q, state_d;
  logic [4:0]      al_hr_q, al_hr_d;
  logic [5:0]      al_min_q, al_min_d;
  logic [4:0]      snz_hr_q, snz_hr_d;
  logic [5:0]      snz_min_q, snz_min_d;
  logic [CW-1:0]   snz_cnt_q, snz_cnt_d;
  logic [TW-1:0]   ring_t_q, ring_t_d;
  logic [BW-1:0]   buzz_cnt_q, buzz_cnt_d;
  logic            buzzer_q, buzzer_d;
  logic            armed_q, armed_d;
  logic            ringing_q, ringing_d;
  logic            snoozing_q, snoozing_d;
  logic [4:0]      btn_prev_q, btn_prev_d;

  logic [4:0]      btn, btn_rise;
  logic            hr_e, min_e, arm_e, snz_e, stop_e;
  logic            match, snz_match;
  logic [6:0]      snz_t;

  // Button rise detection, alarm comparators and snooze target arithmetic
  always_comb begin
    btn       = {bus.stop, bus.snooze, bus.arm_tgl, bus.al_min_inc, bus.al_hr_inc};
    btn_rise  = btn & ~btn_prev_q;
    hr_e      = btn_rise[0];
    min_e     = btn_rise[1];
    arm_e     = btn_rise[2];
    snz_e     = btn_rise[3];
    stop_e    = btn_rise[4];
    match     = (bus.hr == al_hr_q) && (bus.min == al_min_q) && (bus.sec == 6'd0);
    snz_match = (bus.hr == snz_hr_q) && (bus.min == snz_min_q) && (bus.sec == 6'd0);
    snz_t     = {1'b0, bus.min} + SN_ADD;
  end

  // Next-state logic for the alarm setting, FSM, timers and registered outputs
  always_comb begin
    state_d    = state_q;
    al_hr_d    = al_hr_q;
    al_min_d   = al_min_q;
    snz_hr_d   = snz_hr_q;
    snz_min_d  = snz_min_q;
    snz_cnt_d  = snz_cnt_q;
    ring_t_d   = ring_t_q;
    buzz_cnt_d = buzz_cnt_q;
    buzzer_d   = 1'b0;
    btn_prev_d = btn;

    // Alarm setting works in every state; minute wrap never carries into hour
    if (hr_e)
      al_hr_d = (al_hr_q == 5'd23) ? 5'd0 : al_hr_q + 5'd1;
    if (min_e)
      al_min_d = (al_min_q == 6'd59) ? 6'd0 : al_min_q + 6'd1;

    case (state_q)
      IDLE: begin
        if (arm_e) state_d = ARMED;
      end
      ARMED: begin
        if (arm_e) begin
          state_d = IDLE;
        end else if (match) begin
          state_d   = RINGING;
          snz_cnt_d = '0;
          ring_t_d  = '0;
        end
      end
      RINGING: begin
        if (arm_e) begin
          state_d = IDLE;
        end else if (stop_e) begin
          state_d = ARMED;
        end else if (snz_e) begin
          if (snz_cnt_q < SN_MAX) begin
            state_d   = SNOOZE;
            snz_cnt_d = snz_cnt_q + CW'(1);
            if (snz_t >= 7'd60) begin
              snz_min_d = 6'(snz_t - 7'd60);
              snz_hr_d  = (bus.hr == 5'd23) ? 5'd0 : bus.hr + 5'd1;
            end else begin
              snz_min_d = snz_t[5:0];
              snz_hr_d  = bus.hr;
            end
          end else begin
            // Snooze budget used up: the press behaves as stop
            state_d = ARMED;
          end
        end else if (ring_t_q == RT_LAST) begin
          state_d = ARMED;
        end else begin
          ring_t_d = ring_t_q + TW'(1);
        end
      end
      SNOOZE: begin
        if (arm_e) begin
          state_d = IDLE;
        end else if (stop_e) begin
          state_d = ARMED;
        end else if (snz_match) begin
          state_d  = RINGING;
          ring_t_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Buzzer starts low on each ringing entry and is forced low outside RINGING
    if (state_d == RINGING) begin
      if (state_q != RINGING) begin
        buzzer_d   = 1'b0;
        buzz_cnt_d = '0;
      end else if (buzz_cnt_q == BH_LAST) begin
        buzzer_d   = ~buzzer_q;
        buzz_cnt_d = '0;
      end else begin
        buzzer_d   = buzzer_q;
        buzz_cnt_d = buzz_cnt_q + BW'(1);
      end
    end else begin
      buzz_cnt_d = '0;
    end

    armed_d    = (state_d != IDLE);
    ringing_d  = (state_d == RINGING);
    snoozing_d = (state_d == SNOOZE);
  end

  // State and output registers; reset silences everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      al_hr_q    <= '0;
      al_min_q   <= '0;
      snz_hr_q   <= '0;
      snz_min_q  <= '0;
      snz_cnt_q  <= '0;
      ring_t_q   <= '0;
      buzz_cnt_q <= '0;
      buzzer_q   <= 1'b0;
      armed_q    <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      al_hr_q    <= al_hr_d;
      al_min_q   <= al_min_d;
      snz_hr_q   <= snz_hr_d;
      snz_min_q  <= snz_min_d;
      snz_cnt_q  <= snz_cnt_d;
      ring_t_q   <= ring_t_d;
      buzz_cnt_q <= buzz_cnt_d;
      buzzer_q   <= buzzer_d;
      armed_q    <= armed_d;
      ringing_q  <= ringing_d;
      snoozing_q <= snoozing_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  assign bus.al_hr    = al_hr_q;
  assign bus.al_min   = al_min_q;
  assign bus.armed    = armed_q;
  assign bus.ringing  = ringing_q;
  assign bus.snoozing = snoozing_q;
  assign bus.buzzer   = buzzer_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: setting, arming, ringing timeout,
// snooze chain across midnight, stop/arm priorities and reset mid-ring.
module tb_alarm_ctrl;
  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  alarm_ctrl_if bus();

  alarm_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.al_hr_inc  = v;
      1: bus.al_min_inc = v;
      2: bus.arm_tgl    = v;
      3: bus.snooze     = v;
      default: bus.stop = v;
    endcase
  endtask

  // n separate presses of one button, each held one cycle then released
  task automatic press(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      set_btn(b, 1'b1);
      step();
      set_btn(b, 1'b0);
      step();
    end
  endtask

  // Present a time for exactly one sampled edge
  task automatic at(input int h, input int m, input int s);
    bus.hr  = 5'(h);
    bus.min = 6'(m);
    bus.sec = 6'(s);
    step();
  endtask

  initial begin
    int n;
    n_run  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.hr = '0; bus.min = '0; bus.sec = 6'd1;
    bus.al_hr_inc = 0; bus.al_min_inc = 0; bus.arm_tgl = 0;
    bus.snooze = 0; bus.stop = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_al_hr", bus.al_hr, 0);
    chk("rst_al_min", bus.al_min, 0);
    chk("rst_armed", bus.armed, 0);
    chk("rst_ringing", bus.ringing, 0);
    chk("rst_snoozing", bus.snoozing, 0);
    chk("rst_buzzer", bus.buzzer, 0);
    rst = 1'b0;
    step();

    // Held minute button gives a single increment
    set_btn(1, 1'b1);
    repeat (10) step();
    set_btn(1, 1'b0);
    step();
    chk("hold_min", bus.al_min, 1);
    press(1, 58);
    chk("min_59", bus.al_min, 59);
    press(1, 1);
    chk("min_wrap", bus.al_min, 0);
    chk("min_wrap_hr", bus.al_hr, 0);

    // Hour wrap 23->0, then set 06:30
    press(0, 6);
    chk("hr_6", bus.al_hr, 6);
    press(0, 18);
    chk("hr_wrap", bus.al_hr, 0);
    press(0, 6);
    press(1, 30);
    chk("set_hr", bus.al_hr, 6);
    chk("set_min", bus.al_min, 30);

    // Match while IDLE does nothing
    at(6, 30, 0);
    chk("idle_match_ring", bus.ringing, 0);
    chk("idle_match_armed", bus.armed, 0);
    bus.sec = 6'd1;

    press(2, 1);
    chk("arm", bus.armed, 1);

    // Ring, buzzer pattern, timeout after exactly 60 cycles
    at(6, 30, 0);
    chk("ring_rise", bus.ringing, 1);
    chk("buzz_entry", bus.buzzer, 0);
    n = 1;
    for (int i = 1; i < 100 && bus.ringing; i++) begin
      at(6, 30, 1 + (i % 59));
      if (bus.ringing) n++;
      if (i == 1) chk("buzz_t1", bus.buzzer, 1);
      if (i == 2) chk("buzz_t2", bus.buzzer, 0);
    end
    chk("ring_len", n, 60);
    chk("timeout_armed", bus.armed, 1);
    chk("timeout_buzz", bus.buzzer, 0);
    at(6, 30, 30);
    at(6, 30, 31);
    chk("no_retrigger", bus.ringing, 0);

    // Stop and snooze pressed together: stop wins
    at(6, 30, 0);
    chk("ring2", bus.ringing, 1);
    bus.sec = 6'd5;
    bus.stop = 1'b1; bus.snooze = 1'b1;
    step();
    chk("stop_wins_ring", bus.ringing, 0);
    chk("stop_wins_snz", bus.snoozing, 0);
    chk("stop_wins_armed", bus.armed, 1);
    bus.stop = 1'b0; bus.snooze = 1'b0;
    step();

    // Alarm to 23:58, snooze chain across midnight
    press(0, 17);
    press(1, 28);
    chk("set2_hr", bus.al_hr, 23);
    chk("set2_min", bus.al_min, 58);
    at(23, 58, 0);
    chk("ring_2358", bus.ringing, 1);
    bus.sec = 6'd5;
    press(3, 1);
    chk("snz1_snoozing", bus.snoozing, 1);
    chk("snz1_armed", bus.armed, 1);
    chk("snz1_ringing", bus.ringing, 0);
    at(0, 2, 0);
    chk("snz1_early", bus.ringing, 0);
    at(0, 3, 5);
    chk("snz1_sec_gate", bus.ringing, 0);
    at(0, 3, 0);
    chk("snz1_rering", bus.ringing, 1);
    bus.sec = 6'd7;
    press(3, 1);
    chk("snz2_snoozing", bus.snoozing, 1);
    at(0, 8, 0);
    chk("snz2_rering", bus.ringing, 1);
    bus.sec = 6'd7;
    press(3, 1);
    chk("snz3_snoozing", bus.snoozing, 1);
    at(0, 13, 0);
    chk("snz3_rering", bus.ringing, 1);
    bus.sec = 6'd7;
    press(3, 1);
    chk("snz4_ringing", bus.ringing, 0);
    chk("snz4_snoozing", bus.snoozing, 0);
    chk("snz4_armed", bus.armed, 1);

    // arm_tgl while snoozing disarms
    at(23, 58, 0);
    chk("ring_3", bus.ringing, 1);
    bus.sec = 6'd9;
    press(3, 1);
    chk("snz_again", bus.snoozing, 1);
    press(2, 1);
    chk("disarm_armed", bus.armed, 0);
    chk("disarm_snoozing", bus.snoozing, 0);

    // Reset asserted mid-ring silences at once
    press(2, 1);
    at(23, 58, 0);
    chk("ring_4", bus.ringing, 1);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("rstring_ringing", bus.ringing, 0);
    chk("rstring_armed", bus.armed, 0);
    chk("rstring_buzzer", bus.buzzer, 0);
    chk("rstring_al_hr", bus.al_hr, 0);
    step();
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
